time_set_ctrl: RTL and testbench

- Upstream of the clock counter chain.
- Turns two raw push-buttons (MODE, INC) into a hours/minutes edit session.
- On commit, issues a one-cycle load strobe with the new time, which the clock counters accept; the seconds counter is cleared.
- Runs on the same clk as the centisecond counter (100 Hz nominal), so all cycle counts below are in centiseconds.

---
 rtl/clock_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 46 ++++
 rtl/time_set_ctrl.sv | 177 +++++++++++++++++
 tb/tb_time_set_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the clock time-setting logic.
// Latency: none (declarations only).
// Backpressure: not applicable.
package clock_pkg;

  localparam int HOURS_PER_DAY    = 24;
  localparam int MINUTES_PER_HOUR = 60;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_H  = 2'd1,
    SET_M  = 2'd2,
    COMMIT = 2'd3
  } set_state_t;

  localparam logic [1:0] SEL_NONE    = 2'd0;
  localparam logic [1:0] SEL_HOURS   = 2'd1;
  localparam logic [1:0] SEL_MINUTES = 2'd2;

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button to clean level plus one-cycle press pulse.
// Latency: 2 sync flops + DEBOUNCE_CYCLES stable samples from raw edge to press.
// Backpressure: none; a glitch shorter than DEBOUNCE_CYCLES is swallowed.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Synchronize, count consecutive disagreeing samples, flip level once stable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync2;
          press <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Two-button hours/minutes edit session that ends in a one-cycle load strobe.
// Latency: raw edge -> press 2+DEBOUNCE_CYCLES cycles; FSM reacts the cycle after.
// Backpressure: none; simultaneous MODE and INC pulses keep MODE and drop INC.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_RATE     = 10,
  parameter int BLINK_HALF      = 25,
  parameter int TIMEOUT         = 3000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic       load,
  output logic [4:0] load_hours,
  output logic [5:0] load_minutes,
  output logic       setting,
  output logic [1:0] sel,
  output logic       blink
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int BW   = $clog2(BLINK_HALF + 1);

  // MODE only acts on its press edge; its held level has no consumer
  logic mode_level_unused;
  logic mode_press;
  logic inc_level;
  logic inc_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_mode),
    .level (mode_level_unused),
    .press (mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_inc),
    .level (inc_level),
    .press (inc_press)
  );

  // Auto-repeat: rep_cnt counts cycles since the press (or last repeat)
  logic [RW-1:0] rep_cnt;
  logic          rep_fast;
  logic          rep_fire;
  logic          inc_pulse;

  assign rep_fire  = inc_level &&
                     (rep_fast ? (rep_cnt == RW'(REPEAT_RATE)) : (rep_cnt == RW'(REPEAT_DELAY)));
  assign inc_pulse = inc_press | rep_fire;

  // Repeat timer runs only while INC is held; release rearms the long delay
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt  <= '0;
      rep_fast <= 1'b0;
    end else if (!inc_level) begin
      rep_cnt  <= '0;
      rep_fast <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt  <= RW'(1);
      rep_fast <= 1'b1;
    end else begin
      rep_cnt <= rep_cnt + RW'(1);
    end
  end

  set_state_t    state;
  logic [4:0]    edit_h;
  logic [5:0]    edit_m;
  logic [4:0]    next_h;
  logic [5:0]    next_m;
  logic [TW-1:0] to_cnt;
  logic [BW-1:0] blink_cnt;

  // Out-of-range captured values also wrap to zero on the next increment
  assign next_h = (edit_h >= 5'(HOURS_PER_DAY - 1))    ? 5'd0 : edit_h + 5'd1;
  assign next_m = (edit_m >= 6'(MINUTES_PER_HOUR - 1)) ? 6'd0 : edit_m + 6'd1;

  // Edit-session FSM with timeout, blink phase and registered load outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      edit_h       <= '0;
      edit_m       <= '0;
      load         <= 1'b0;
      load_hours   <= '0;
      load_minutes <= '0;
      blink        <= 1'b0;
      blink_cnt    <= '0;
      to_cnt       <= '0;
    end else begin
      load <= 1'b0;
      case (state)
        RUN: begin
          blink     <= 1'b0;
          blink_cnt <= '0;
          to_cnt    <= '0;
          if (mode_press) begin
            edit_h <= cur_hours;
            edit_m <= cur_minutes;
            state  <= SET_H;
          end
        end
        SET_H, SET_M: begin
          // Blink first; leaving the edit states below overrides it to 0
          if (inc_pulse) begin
            blink     <= 1'b0;
            blink_cnt <= '0;
          end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
            blink     <= ~blink;
            blink_cnt <= '0;
          end else begin
            blink_cnt <= blink_cnt + BW'(1);
          end

          if (mode_press) begin
            to_cnt <= '0;
            if (state == SET_H) begin
              state <= SET_M;
            end else begin
              state        <= COMMIT;
              load         <= 1'b1;
              load_hours   <= edit_h;
              load_minutes <= edit_m;
              blink        <= 1'b0;
            end
          end else if (inc_pulse) begin
            to_cnt <= '0;
            if (state == SET_H) edit_h <= next_h;
            else                edit_m <= next_m;
          end else if (to_cnt == TW'(TIMEOUT - 1)) begin
            to_cnt <= '0;
            state  <= RUN;
            blink  <= 1'b0;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        COMMIT: begin
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Edit indicators are pure decodes of the state
  always_comb begin
    setting = 1'b0;
    sel     = SEL_NONE;
    case (state)
      SET_H: begin
        setting = 1'b1;
        sel     = SEL_HOURS;
      end
      SET_M: begin
        setting = 1'b1;
        sel     = SEL_MINUTES;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;

  localparam int DELAY = 50;
  localparam int RATE  = 10;
  localparam int TOUT  = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic       load;
  logic [4:0] load_hours;
  logic [5:0] load_minutes;
  logic       setting;
  logic [1:0] sel;
  logic       blink;

  int n_tests = 0;
  int n_fail  = 0;

  int         load_cnt = 0;
  logic [4:0] last_h = '0;
  logic [5:0] last_m = '0;

  time_set_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .cur_hours    (cur_hours),
    .cur_minutes  (cur_minutes),
    .load         (load),
    .load_hours   (load_hours),
    .load_minutes (load_minutes),
    .setting      (setting),
    .sel          (sel),
    .blink        (blink)
  );

  always #5 clk = ~clk;

  // Count every cycle load is high and capture what was offered
  always @(negedge clk) begin
    if (load === 1'b1) begin
      load_cnt = load_cnt + 1;
      last_h   = load_hours;
      last_m   = load_minutes;
    end
  end

  // ---------------- reference model (rule level) ----------------
  function automatic int exp_field(input int start, input int n, input int modulus);
    if (start < modulus) return (start + n) % modulus;
    if (n == 0) return start;
    return (n - 1) % modulus;
  endfunction

  // Debounced level stays high for as many cycles as the raw button was sampled high
  function automatic int incs_for_hold(input int n);
    if (n > DELAY) return 1 + (n - 1 - DELAY) / RATE + 1;
    return 1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    tick(6);
    btn_mode = 1'b0;
    tick(8);
  endtask

  task automatic press_inc_hold(input int n);
    btn_inc = 1'b1;
    tick(n);
    btn_inc = 1'b0;
    tick(8);
  endtask

  task automatic run_session(input int h0, input int m0, input int nh, input int nm,
                             output int loads, output int gh, output int gm);
    int l0;
    cur_hours   = 5'(h0);
    cur_minutes = 6'(m0);
    press_mode();
    for (int i = 0; i < nh; i++) press_inc_hold(6);
    press_mode();
    for (int i = 0; i < nm; i++) press_inc_hold(6);
    l0 = load_cnt;
    press_mode();
    loads = load_cnt - l0;
    gh    = int'(last_h);
    gm    = int'(last_m);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    cur_hours = 5'd13; cur_minutes = 6'd45;
    tick(3);
    n_tests++;
    if ({load, load_hours, load_minutes, setting, sel, blink} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {load, load_hours, load_minutes, setting, sel, blink});
    end
    @(negedge clk);
    rst = 1'b1;
    tick(2);
  endtask

  task automatic test_idle();
    int bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (load !== 1'b0 || setting !== 1'b0 || sel !== 2'd0 || blink !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0 || load_cnt != 0) begin
      n_fail++;
      $display("FAIL idle_quiet: got %0d bad cycles, %0d loads, expected 0 and 0", bad, load_cnt);
    end
  endtask

  task automatic test_latency_commit();
    int edges = 0;
    int l0;
    cur_hours = 5'd13; cur_minutes = 6'd45;
    btn_mode = 1'b1;
    while (setting !== 1'b1 && edges < 20) begin
      tick(1);
      edges++;
    end
    // press pulse after 4 edges, state register one edge later
    n_tests++;
    if (edges != 5) begin
      n_fail++;
      $display("FAIL mode_latency: got %0d edges expected 5", edges);
    end
    n_tests++;
    if (sel !== 2'd1) begin
      n_fail++;
      $display("FAIL sel_hours: got %0d expected 1", sel);
    end
    tick(1);
    btn_mode = 1'b0;
    tick(11);
    n_tests++;
    if (blink !== 1'b0) begin n_fail++; $display("FAIL blink_phase0: got %b expected 0", blink); end
    tick(25);
    n_tests++;
    if (blink !== 1'b1) begin n_fail++; $display("FAIL blink_phase1: got %b expected 1", blink); end
    tick(25);
    n_tests++;
    if (blink !== 1'b0) begin n_fail++; $display("FAIL blink_phase2: got %b expected 0", blink); end
    for (int i = 0; i < 3; i++) press_inc_hold(6);
    n_tests++;
    if (blink !== 1'b0) begin n_fail++; $display("FAIL blink_after_inc: got %b expected 0", blink); end
    press_mode();
    n_tests++;
    if (sel !== 2'd2 || setting !== 1'b1) begin
      n_fail++;
      $display("FAIL sel_minutes: got sel=%0d setting=%b expected 2 1", sel, setting);
    end
    l0 = load_cnt;
    press_mode();
    n_tests++;
    if (load_cnt - l0 != 1 || int'(last_h) != exp_field(13, 3, 24) || int'(last_m) != 45) begin
      n_fail++;
      $display("FAIL commit_16_45: got loads=%0d %0d:%0d expected 1 %0d:45",
               load_cnt - l0, last_h, last_m, exp_field(13, 3, 24));
    end
    n_tests++;
    if (setting !== 1'b0 || sel !== 2'd0 || load !== 1'b0 || load_hours !== 5'(exp_field(13, 3, 24))) begin
      n_fail++;
      $display("FAIL back_to_run: got setting=%b sel=%0d load=%b hold=%0d expected 0 0 0 16",
               setting, sel, load, load_hours);
    end
  endtask

  task automatic test_wrap_random();
    int h0, m0, nh, nm, loads, gh, gm;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: begin h0 = 10; m0 = 58; nh = 0; nm = 1; end
        1: begin h0 = 10; m0 = 58; nh = 0; nm = 2; end
        2: begin h0 = 23; m0 = 5;  nh = 1; nm = 0; end
        3: begin h0 = 30; m0 = 62; nh = 1; nm = 1; end
        default: begin
          h0 = int'($urandom_range(0, 31)); m0 = int'($urandom_range(0, 63));
          nh = int'($urandom_range(0, 5));  nm = int'($urandom_range(0, 5));
        end
      endcase
      run_session(h0, m0, nh, nm, loads, gh, gm);
      n_tests++;
      if (loads != 1 || gh != exp_field(h0, nh, 24) || gm != exp_field(m0, nm, 60)) begin
        n_fail++;
        $display("FAIL session_%0d: start %0d:%0d +%0d/+%0d got loads=%0d %0d:%0d expected 1 %0d:%0d",
                 i, h0, m0, nh, nm, loads, gh, gm, exp_field(h0, nh, 24), exp_field(m0, nm, 60));
      end
    end
  endtask

  task automatic test_repeat_glitch();
    int holds[2];
    int m0, l0;
    holds[0] = 100;
    holds[1] = int'($urandom_range(40, 150));
    for (int k = 0; k < 2; k++) begin
      m0 = int'($urandom_range(0, 59));
      cur_hours = 5'd0; cur_minutes = 6'(m0);
      press_mode();
      press_inc_hold(holds[k]);
      btn_inc = 1'b1;
      tick(1);
      btn_inc = 1'b0;
      tick(8);
      press_mode();
      l0 = load_cnt;
      press_mode();
      n_tests++;
      if (load_cnt - l0 != 1 || int'(last_h) != exp_field(0, incs_for_hold(holds[k]), 24) ||
          int'(last_m) != m0) begin
        n_fail++;
        $display("FAIL repeat_hold_%0d: got loads=%0d %0d:%0d expected 1 %0d:%0d",
                 holds[k], load_cnt - l0, last_h, last_m,
                 exp_field(0, incs_for_hold(holds[k]), 24), m0);
      end
    end
  endtask

  task automatic test_timeout();
    int edges = 0;
    int l0 = load_cnt;
    cur_hours = 5'(int'($urandom_range(0, 23))); cur_minutes = 6'd30;
    btn_mode = 1'b1;
    while (setting !== 1'b1 && edges < 20) begin
      tick(1);
      edges++;
    end
    n_tests++;
    if (setting !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_entry: got setting=%b expected 1", setting);
    end
    edges = 0;
    while (setting === 1'b1 && edges < TOUT + 200) begin
      tick(1);
      edges++;
      if (edges == 3) btn_mode = 1'b0;
    end
    btn_mode = 1'b0;
    n_tests++;
    if (edges != TOUT) begin
      n_fail++;
      $display("FAIL timeout_cycles: got %0d expected %0d", edges, TOUT);
    end
    tick(5);
    n_tests++;
    if (load_cnt != l0 || sel !== 2'd0 || blink !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_no_load: got loads=%0d sel=%0d blink=%b expected 0 0 0",
               load_cnt - l0, sel, blink);
    end
  endtask

  task automatic test_simultaneous();
    int l0;
    cur_hours = 5'd7; cur_minutes = 6'd20;
    press_mode();
    btn_mode = 1'b1; btn_inc = 1'b1;
    tick(6);
    btn_mode = 1'b0; btn_inc = 1'b0;
    tick(8);
    n_tests++;
    if (sel !== 2'd2) begin
      n_fail++;
      $display("FAIL simul_to_setm: got sel=%0d expected 2", sel);
    end
    l0 = load_cnt;
    press_mode();
    n_tests++;
    if (load_cnt - l0 != 1 || last_h !== 5'd7 || last_m !== 6'd20) begin
      n_fail++;
      $display("FAIL simul_inc_dropped: got loads=%0d %0d:%0d expected 1 7:20",
               load_cnt - l0, last_h, last_m);
    end
  endtask

  task automatic test_async_reset();
    int l0;
    cur_hours = 5'd9; cur_minutes = 6'd9;
    press_mode();
    press_mode();
    press_inc_hold(6);
    n_tests++;
    if (sel !== 2'd2 || load_hours !== 5'd7) begin
      n_fail++;
      $display("FAIL pre_reset_state: got sel=%0d load_hours=%0d expected 2 7", sel, load_hours);
    end
    l0 = load_cnt;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({load, load_hours, load_minutes, setting, sel, blink} !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %h expected 0",
               {load, load_hours, load_minutes, setting, sel, blink});
    end
    tick(3);
    rst = 1'b1;
    tick(20);
    n_tests++;
    if (load_cnt != l0 || setting !== 1'b0 || sel !== 2'd0 || load_hours !== 5'd0) begin
      n_fail++;
      $display("FAIL after_reset_run: got loads=%0d setting=%b sel=%0d lh=%0d expected 0 0 0 0",
               load_cnt - l0, setting, sel, load_hours);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_latency_commit();
    test_wrap_random();
    test_repeat_glitch();
    test_timeout();
    test_simultaneous();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
